// File: rtl/freq_meter_32_if.sv
// freq_meter_32 bus: enable and signal in, result, strobe and overflow out.
`timescale 1ns/100ps
interface freq_meter_32_if;
  logic        en;
  logic        sig_in;
  logic [31:0] bin;
  logic        valid;
  logic        ovf;

  modport master (
    output en,
    output sig_in,
    input  bin,
    input  valid,
    input  ovf
  );

  modport slave (
    input  en,
    input  sig_in,
    output bin,
    output valid,
    output ovf
  );
endinterface

// File: rtl/freq_meter_32.sv
// Gated-count frequency meter: counts synchronised rising edges of sig_in
// over back-to-back windows of GATE_CYCLES clocks, saturating at CNT_W bits.
`timescale 1ns/100ps
module freq_meter_32 #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter logic [31:0] GATE_CYCLES = CLK_FREQ,
  parameter int          CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  freq_meter_32_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2
  } state_t;

  localparam logic [31:0]      LAST = GATE_CYCLES - 32'd1;
  localparam logic [CNT_W-1:0] MAX  = '1;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  state_t           r_state;
  logic [31:0]      r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_sat;
  logic [31:0]      r_bin;
  logic             r_valid;
  logic             r_ovf;

  logic             w_rise;
  logic             w_full;
  logic [CNT_W-1:0] w_sum;
  logic             w_sum_sat;
  state_t           w_nstate;
  logic [31:0]      w_gate_nxt;
  logic [CNT_W-1:0] w_edge_nxt;
  logic             w_sat_nxt;
  logic             w_pub;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_full    = (r_edge_cnt == MAX);
  assign w_sum     = w_full ? MAX : r_edge_cnt + CNT_W'(w_rise);
  assign w_sum_sat = r_sat | (w_full & w_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_gate_nxt = r_gate_cnt;
    w_edge_nxt = r_edge_cnt;
    w_sat_nxt  = r_sat;
    w_pub      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_gate_nxt = '0;
        w_edge_nxt = '0;
        w_sat_nxt  = 1'b0;
        if (bus.en) w_nstate = SETTLE;
      end
      SETTLE: begin
        w_edge_nxt = '0;
        w_sat_nxt  = 1'b0;
        if (!bus.en) begin
          w_nstate   = IDLE;
          w_gate_nxt = '0;
        end else if (r_gate_cnt == 32'd2) begin
          w_nstate   = GATE;
          w_gate_nxt = '0;
        end else begin
          w_gate_nxt = r_gate_cnt + 32'd1;
        end
      end
      GATE: begin
        // a rise in the terminal cycle still belongs to the closing gate
        if (r_gate_cnt == LAST) begin
          w_pub      = 1'b1;
          w_gate_nxt = '0;
          w_edge_nxt = '0;
          w_sat_nxt  = 1'b0;
          if (!bus.en) w_nstate = IDLE;
        end else if (!bus.en) begin
          w_nstate   = IDLE;
          w_gate_nxt = '0;
          w_edge_nxt = '0;
          w_sat_nxt  = 1'b0;
        end else begin
          w_gate_nxt = r_gate_cnt + 32'd1;
          w_edge_nxt = w_sum;
          w_sat_nxt  = w_sum_sat;
        end
      end
      default: begin
        w_nstate   = IDLE;
        w_gate_nxt = '0;
        w_edge_nxt = '0;
        w_sat_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_bin      <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_gate_cnt <= w_gate_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_sat      <= w_sat_nxt;
      r_valid    <= w_pub;
      if (w_pub) begin
        r_bin <= 32'(w_sum);
        r_ovf <= w_sum_sat;
      end
    end
  end

  assign bus.bin   = r_bin;
  assign bus.valid = r_valid;
  assign bus.ovf   = r_ovf;

endmodule
